// File: rtl/mul_unit.sv
// Iterative 32x32 multiplier: MUL, UMULL and SMULL.
// Uses radix-2 shift-add over 32 cycles, then a sign fix-up cycle and a one-cycle done pulse.
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic [1:0]  nz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_UMULL = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;

    state_t      state;
    state_t      nxt;
    logic [2:0]  op_q;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        sign;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] fix_val;
    logic        op_ok;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign op_ok = start && (op == OP_MUL || op == OP_UMULL || op == OP_SMULL);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign fix_val = (op_q == OP_SMULL && sign) ? (~acc + 64'd1) : acc;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (op_ok) nxt = CALC;
                CALC: if (cnt == 5'd31) nxt = FIX;
                FIX:  nxt = DONE;
                DONE: nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= 3'b000;
            ma        <= 32'd0;
            mb        <= 32'd0;
            sign      <= 1'b0;
            cnt       <= 5'd0;
            acc       <= 64'd0;
            result_lo <= 32'd0;
            result_hi <= 32'd0;
            nz        <= 2'b00;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (op_ok) begin
                        op_q <= op;
                        ma   <= (op == OP_SMULL) ? abs_a : a;
                        mb   <= (op == OP_SMULL) ? abs_b : b;
                        sign <= (op == OP_SMULL) && (a[31] ^ b[31]);
                        cnt  <= 5'd0;
                        acc  <= 64'd0;
                    end
                end
                CALC: begin
                    if (mb[cnt]) acc <= acc + ({32'd0, ma} << cnt);
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    result_lo <= fix_val[31:0];
                    if (op_q == OP_MUL) begin
                        result_hi <= 32'd0;
                        nz <= {fix_val[31], fix_val[31:0] == 32'd0};
                    end else begin
                        result_hi <= fix_val[63:32];
                        nz <= {fix_val[63], fix_val == 64'd0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [1:0]  nz;

    int vectors = 0;
    int miscompares = 0;

    mul_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .nz(nz)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request and waits (bounded) for done; n = cycles after accept.
    task automatic launch(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int n);
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = 0; b = 0;
        tick(); tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl busy=%b done=%b expected 0 0", busy, done);
        end
        vectors++;
        if (result_lo !== 32'd0 || result_hi !== 32'd0 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_res got %h_%h nz=%b expected 0_0 nz=00",
                     result_hi, result_lo, nz);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_umull;
        int n;
        launch(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        vectors++;
        if (n !== 33 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL umull_latency n=%0d busy=%b expected 33 1", n, busy);
        end
        vectors++;
        if (result_hi !== 32'hFFFFFFFE || result_lo !== 32'h00000001 || nz !== 2'b10) begin
            miscompares++;
            $display("FAIL umull_max got %h_%h nz=%b expected fffffffe_00000001 nz=10",
                     result_hi, result_lo, nz);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL umull_end done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_smull;
        int n;
        launch(3'b110, 32'hFFFFFFFF, 32'h00000001, n);
        vectors++;
        if (n !== 33 || result_hi !== 32'hFFFFFFFF || result_lo !== 32'hFFFFFFFF || nz !== 2'b10) begin
            miscompares++;
            $display("FAIL smull_m1 n=%0d got %h_%h nz=%b expected ffffffff_ffffffff nz=10",
                     n, result_hi, result_lo, nz);
        end
        launch(3'b110, 32'h80000000, 32'h80000000, n);
        vectors++;
        if (result_hi !== 32'h40000000 || result_lo !== 32'h0 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL smull_min got %h_%h nz=%b expected 40000000_00000000 nz=00",
                     result_hi, result_lo, nz);
        end
        launch(3'b110, 32'hFFFFFFFD, 32'h00000005, n);
        vectors++;
        if (result_hi !== 32'hFFFFFFFF || result_lo !== 32'hFFFFFFF1 || nz !== 2'b10) begin
            miscompares++;
            $display("FAIL smull_neg15 got %h_%h nz=%b expected ffffffff_fffffff1 nz=10",
                     result_hi, result_lo, nz);
        end
    endtask

    task automatic test_mul;
        int n;
        launch(3'b100, 32'h00010000, 32'h00010000, n);
        vectors++;
        if (n !== 33 || result_hi !== 32'h0 || result_lo !== 32'h0 || nz !== 2'b01) begin
            miscompares++;
            $display("FAIL mul_zero n=%0d got %h_%h nz=%b expected 0_0 nz=01",
                     n, result_hi, result_lo, nz);
        end
        launch(3'b100, 32'hFFFFFFFF, 32'h00000002, n);
        vectors++;
        if (result_hi !== 32'h0 || result_lo !== 32'hFFFFFFFE || nz !== 2'b10) begin
            miscompares++;
            $display("FAIL mul_neg got %h_%h nz=%b expected 0_fffffffe nz=10",
                     result_hi, result_lo, nz);
        end
        launch(3'b100, 32'd7, 32'd6, n);
        vectors++;
        if (result_hi !== 32'h0 || result_lo !== 32'd42 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL mul_42 got %h_%h nz=%b expected 0_0000002a nz=00",
                     result_hi, result_lo, nz);
        end
        tick();
    endtask

    task automatic test_invalid_op;
        logic seen;
        seen = 1'b0;
        op = 3'b010; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        op = 3'b111;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_op_busy got %b expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || result_lo !== 32'd42 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL bad_op_hold done_seen=%b lo=%h nz=%b expected 0 0000002a 00",
                     seen, result_lo, nz);
        end
    endtask

    task automatic test_flush;
        int n;
        logic seen;
        seen = 1'b0;
        op = 3'b101; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre_busy got %b expected 1", busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy got %b expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || result_lo !== 32'd42 || result_hi !== 32'd0) begin
            miscompares++;
            $display("FAIL flush_hold done_seen=%b got %h_%h expected 0 0_0000002a",
                     seen, result_hi, result_lo);
        end
        launch(3'b100, 32'd3, 32'd5, n);
        vectors++;
        if (n !== 33 || result_lo !== 32'd15) begin
            miscompares++;
            $display("FAIL flush_next n=%0d lo=%0d expected 33 15", n, result_lo);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        int n;
        logic seen;
        seen = 1'b0;
        op = 3'b101; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || result_lo !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_async busy=%b lo=%h expected 0 00000000", busy, result_lo);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort done_seen=%b busy=%b expected 0 0", seen, busy);
        end
        launch(3'b100, 32'd3, 32'd5, n);
        vectors++;
        if (n !== 33 || result_lo !== 32'd15 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_next n=%0d lo=%0d nz=%b expected 33 15 00", n, result_lo, nz);
        end
        tick();
    endtask

    task automatic test_flush_start;
        flush = 1'b1; start = 1'b1; op = 3'b100; a = 32'd2; b = 32'd2;
        tick();
        flush = 1'b0; start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_start busy=%b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_operand_change;
        int n;
        op = 3'b101; a = 32'h00012345; b = 32'h00000100; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            a = a + 32'h11111111;
            b = ~b;
            op = op + 3'd1;
            start = n[0];
            tick();
            n++;
        end
        start = 1'b0;
        vectors++;
        if (n !== 33 || result_hi !== 32'h0 || result_lo !== 32'h01234500 || nz !== 2'b00) begin
            miscompares++;
            $display("FAIL op_change n=%0d got %h_%h nz=%b expected 33 0_01234500 nz=00",
                     n, result_hi, result_lo, nz);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        launch(3'b100, 32'd2, 32'd3, n);
        op = 3'b100; a = 32'd4; b = 32'd5; start = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || result_lo !== 32'd6) begin
            miscompares++;
            $display("FAIL b2b_done_ignore busy=%b lo=%0d expected 0 6", busy, result_lo);
        end
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept busy=%b expected 1", busy);
        end
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        vectors++;
        if (n !== 33 || result_lo !== 32'd20) begin
            miscompares++;
            $display("FAIL b2b_result n=%0d lo=%0d expected 33 20", n, result_lo);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_umull();
        test_smull();
        test_mul();
        test_invalid_op();
        test_flush();
        test_reset_abort();
        test_flush_start();
        test_operand_change();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
